float_to_fix_arb: RTL
=====================

FLOAT_TO_FIX_ARB -- requirements
Module: float_to_fix_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one converter (2..16).
REQ-002 SHALL have parameter FLOAT_OP_WIDTH, default 16: width of the floating-point operand.
REQ-003 SHALL have parameter EXP_MSB_POS, default 14: exponent MSB position. Parameter EXP_LSB_POS, default 10: exponent LSB position.
REQ-004 SHALL have parameter FIXED_OP_WIDTH, default 80: width of the fixed-point result.
REQ-005 SHALL have port clk_i  input  1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port req_valid_i  input  NUM_REQ: per-requester operand valid.
REQ-008 SHALL have port req_ready_o  output  NUM_REQ: per-requester accept, one-hot or zero.
REQ-009 SHALL have port req_operand_i  input  NUM_REQ x FLOAT_OP_WIDTH: per-requester float operand.
REQ-010 SHALL have port rsp_valid_o  output  1: result valid. Port rsp_ready_i  input  1: consumer accepts result.
REQ-011 SHALL have port rsp_id_o  output  $clog2(NUM_REQ): index of the requester owning the result.
REQ-012 SHALL have port rsp_value_o  output  FIXED_OP_WIDTH: two's-complement fixed-point result.
REQ-013 SHALL have ports rsp_nan_o, rsp_snan_o, rsp_inf_o  output  1 each: exception flags of the result.
REQ-014 SHALL have port exc_cnt_o  output  16: saturating count of delivered results with nan or inf set.

Function
REQ-015 SHALL implement FSM states IDLE, CONV, RESP.
REQ-016 IDLE: when any req_valid_i is set, assert req_ready_o for exactly one granted index, chosen round-robin starting at rr_ptr; otherwise req_ready_o = 0.
REQ-017 IDLE: handshake (valid & ready) at cycle N SHALL register the operand and id and move to CONV at N+1.
REQ-018 CONV: converter output (value, flags) SHALL be captured into the response registers; rsp_valid_o SHALL rise at N+2; move to RESP.
REQ-019 RESP: hold rsp_valid_o and all rsp_* outputs stable until rsp_ready_i=1; on that edge go to IDLE, with rsp_valid_o=0 next cycle.
REQ-020 SHALL NOT assert req_ready_o in CONV or RESP; throughput is at most one result per 3 cycles.
REQ-021 rr_ptr SHALL update only on an accept handshake, to (grant+1) mod NUM_REQ; non-power-of-2 NUM_REQ wraps correctly.
REQ-022 Requesters SHALL keep valid and operand stable until accepted; req_ready_o may depend combinationally on req_valid_i; req_valid_i SHALL NOT depend on req_ready_o.
REQ-023 exc_cnt_o SHALL increment on each rsp handshake with rsp_nan_o|rsp_inf_o; it saturates at 0xFFFF. A sNaN result also has rsp_nan_o set.
REQ-024 Conversion rule: normal input gives ({1,mantissa} << (exp-1)); exp=0 gives mantissa unshifted; a set sign bit gives the two's complement; the result is truncated to FIXED_OP_WIDTH.

Reset
REQ-025 Reset SHALL set state=IDLE, rr_ptr=0, rsp_valid_o=0, rsp_id_o=0, rsp_value_o=0, all flags=0, exc_cnt_o=0; req_ready_o is 0 during reset.
REQ-026 Reset asserted in CONV or RESP SHALL discard the in-flight operation with no response and no counter update.

Structure
REQ-027 A package float_to_fix_pkg SHALL hold the state enum typedef and the default width/position constants.
REQ-028 The block SHALL instantiate exactly one float_to_fix sub-module as the shared datapath; when its SVA ports are compiled in, connect clk_i and ~rst_i.
REQ-029 Round-robin grant logic SHALL be combinational, with registered rr_ptr; all outputs except req_ready_o are registered.

Verification
REQ-030 Requester 0 sends 0x3C00, rsp_ready_i=1 -> rsp_valid_o at N+2, rsp_value_o=0x1000000, rsp_id_o=0, flags 0.
REQ-031 Requester 2 sends 0xBC00 -> rsp_value_o=80'hFFFF_FFFF_FFFF_FF00_0000, id 2.
REQ-032 All 4 requesters valid continuously from reset -> grant order 0,1,2,3,0; one req_ready_o bit at a time.
REQ-033 Operands 0x7C00, 0x7E00, 0x7C01 -> inf / nan / nan+snan respectively; exc_cnt_o ends at 3.
REQ-034 rsp_ready_i held low 5 cycles in RESP -> rsp_* stable, req_ready_o=0, no new grant; release -> IDLE next cycle.
REQ-035 rst_i pulsed for 1 cycle while in CONV -> no rsp_valid_o, exc_cnt_o=0, next grant from index 0.

Source files
------------

// File: rtl/float_to_fix_pkg.sv
// Shared types and default geometry for the arbitrated float-to-fixed converter.
// Defaults describe a half-precision operand widened to an 80-bit fixed-point result.
package float_to_fix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_FLOAT_OP_WIDTH = 16;
  localparam int DEF_EXP_MSB_POS    = 14;
  localparam int DEF_EXP_LSB_POS    = 10;
  localparam int DEF_FIXED_OP_WIDTH = 80;

endpackage

// File: rtl/float_to_fix.sv
// Combinational float-to-fixed datapath shared by all requesters.
// The clock and active-low reset ports exist only to clock the flag-consistency property.
module float_to_fix
  import float_to_fix_pkg::*;
#(
  parameter int FLOAT_OP_WIDTH = DEF_FLOAT_OP_WIDTH,
  parameter int EXP_MSB_POS    = DEF_EXP_MSB_POS,
  parameter int EXP_LSB_POS    = DEF_EXP_LSB_POS,
  parameter int FIXED_OP_WIDTH = DEF_FIXED_OP_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FLOAT_OP_WIDTH-1:0] operand,
  output logic [FIXED_OP_WIDTH-1:0] value,
  output logic                      nan,
  output logic                      snan,
  output logic                      inf
);

  localparam int EXP_W = EXP_MSB_POS - EXP_LSB_POS + 1;
  localparam int MAN_W = EXP_LSB_POS;

  logic                      sign;
  logic [EXP_W-1:0]          exp_field;
  logic [MAN_W-1:0]          man;
  logic                      exp_max;
  logic [FIXED_OP_WIDTH-1:0] mag;

  // A zero exponent passes the raw mantissa through; otherwise the hidden bit is restored.
  always_comb begin
    sign      = operand[FLOAT_OP_WIDTH-1];
    exp_field = operand[EXP_MSB_POS:EXP_LSB_POS];
    man       = operand[MAN_W-1:0];
    exp_max   = &exp_field;
    if (exp_field == '0) begin
      mag = FIXED_OP_WIDTH'(man);
    end else begin
      mag = FIXED_OP_WIDTH'({1'b1, man}) << (exp_field - EXP_W'(1));
    end
    value = sign ? -mag : mag;
    nan   = exp_max && (man != '0);
    snan  = exp_max && (man != '0) && !man[MAN_W-1];
    inf   = exp_max && (man == '0);
  end

  snan_implies_nan: assert property (@(posedge clk) disable iff (!rst_n) snan |-> nan);

endmodule

// File: rtl/float_to_fix_arb.sv
// Round-robin arbiter sharing one float-to-fixed converter among NUM_REQ requesters.
// One operation is in flight at a time: accept, convert, then hold the response until taken.
module float_to_fix_arb
  import float_to_fix_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int FLOAT_OP_WIDTH = DEF_FLOAT_OP_WIDTH,
  parameter int EXP_MSB_POS    = DEF_EXP_MSB_POS,
  parameter int EXP_LSB_POS    = DEF_EXP_LSB_POS,
  parameter int FIXED_OP_WIDTH = DEF_FIXED_OP_WIDTH
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  output logic [NUM_REQ-1:0]                     req_ready_o,
  input  logic [NUM_REQ-1:0][FLOAT_OP_WIDTH-1:0] req_operand_i,
  output logic                                   rsp_valid_o,
  input  logic                                   rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]             rsp_id_o,
  output logic [FIXED_OP_WIDTH-1:0]              rsp_value_o,
  output logic                                   rsp_nan_o,
  output logic                                   rsp_snan_o,
  output logic                                   rsp_inf_o,
  output logic [15:0]                            exc_cnt_o
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t                    state, state_next;
  logic [ID_W-1:0]           rr_ptr, grant_id, op_id;
  logic                      grant_any, accept;
  logic [FLOAT_OP_WIDTH-1:0] op_q;
  logic [FIXED_OP_WIDTH-1:0] conv_value;
  logic                      conv_nan, conv_snan, conv_inf;

  // Scan from rr_ptr upward with wrap; iterating downward lets the closest valid index win.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    sum       = '0;
    idx       = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (req_valid_i[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = CONV;
      CONV:    state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (state == IDLE && !rst_i && grant_any) req_ready_o[grant_id] = 1'b1;
  end

  assign accept = |(req_ready_o & req_valid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      op_q        <= '0;
      op_id       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_value_o <= '0;
      rsp_nan_o   <= 1'b0;
      rsp_snan_o  <= 1'b0;
      rsp_inf_o   <= 1'b0;
      exc_cnt_o   <= '0;
    end else begin
      if (accept) begin
        op_q   <= req_operand_i[grant_id];
        op_id  <= grant_id;
        rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
      end
      if (state == CONV) begin
        rsp_valid_o <= 1'b1;
        rsp_id_o    <= op_id;
        rsp_value_o <= conv_value;
        rsp_nan_o   <= conv_nan;
        rsp_snan_o  <= conv_snan;
        rsp_inf_o   <= conv_inf;
      end
      if (state == RESP && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
        if ((rsp_nan_o || rsp_inf_o) && exc_cnt_o != 16'hFFFF) exc_cnt_o <= exc_cnt_o + 16'd1;
      end
    end
  end

  float_to_fix #(
    .FLOAT_OP_WIDTH(FLOAT_OP_WIDTH),
    .EXP_MSB_POS   (EXP_MSB_POS),
    .EXP_LSB_POS   (EXP_LSB_POS),
    .FIXED_OP_WIDTH(FIXED_OP_WIDTH)
  ) u_conv (
    .clk    (clk_i),
    .rst_n  (~rst_i),
    .operand(op_q),
    .value  (conv_value),
    .nan    (conv_nan),
    .snan   (conv_snan),
    .inf    (conv_inf)
  );

endmodule
